// File: rtl/gsim_pkg.sv
// Shared types, widths and helpers for the Gauss-Seidel sequencer.
package gsim_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int B_W  = 16;
    localparam int X_W  = 32;
    localparam int PE_W = 38;
    localparam int NB   = 6;   // neighbour operands per row

    // Counter width able to index 0..n-1 (at least one bit).
    function automatic int idx_w(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

    // Neighbour offset for operand slot i: pe_in_1..pe_in_6 = +3,-3,+2,-2,+1,-1.
    function automatic int nb_offset(input int i);
        int off;
        case (i)
            0:       off = 3;
            1:       off = -3;
            2:       off = 2;
            3:       off = -2;
            4:       off = 1;
            default: off = -1;
        endcase
        return off;
    endfunction

    // Clamp a 38-bit PE result into the signed 32-bit x range.
    function automatic logic signed [X_W-1:0] sat38to32(input logic signed [PE_W-1:0] v);
        logic signed [X_W-1:0] r;
        if (v[PE_W-1:X_W-1] == '0 || v[PE_W-1:X_W-1] == '1) begin
            r = v[X_W-1:0];
        end else if (v[PE_W-1]) begin
            r = {1'b1, {(X_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(X_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/gsim_ctrl_if.sv
// Bundle of the b input stream, x output stream and PE operand/result bus.
// master = the sequencer side, slave = the environment (source, sink, PE).
interface gsim_ctrl_if;
    logic                              b_valid;
    logic signed [gsim_pkg::B_W-1:0]   b_data;
    logic                              b_ready;
    logic                              x_valid;
    logic signed [gsim_pkg::X_W-1:0]   x_data;
    logic                              x_ready;
    logic                              busy;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_1;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_2;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_3;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_4;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_5;
    logic signed [gsim_pkg::X_W-1:0]   pe_in_6;
    logic signed [gsim_pkg::B_W-1:0]   pe_b;
    logic signed [gsim_pkg::PE_W-1:0]  pe_out;

    modport master (
        input  b_valid, b_data, x_ready, pe_out,
        output b_ready, x_valid, x_data, busy,
               pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6, pe_b
    );

    modport slave (
        output b_valid, b_data, x_ready, pe_out,
        input  b_ready, x_valid, x_data, busy,
               pe_in_1, pe_in_2, pe_in_3, pe_in_4, pe_in_5, pe_in_6, pe_b
    );
endinterface

// File: rtl/gsim_xbank.sv
// Solution-vector register file: one write port, and a read port returning the
// centre entry plus its six neighbours. Reads bypass a same-cycle write so the
// next row sees the value being written back.
module gsim_xbank
    import gsim_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        we_i,
    input  logic [idx_w(N)-1:0]         waddr_i,
    input  logic signed [X_W-1:0]       wdata_i,
    input  logic [idx_w(N)-1:0]         centre_i,
    output logic signed [X_W-1:0]       rd_c_o,
    output logic signed [X_W-1:0]       rd_n_o [NB]
);
    localparam int IW = idx_w(N);

    logic signed [X_W-1:0] mem_q [N];

    // Storage: cleared by reset or at job start, otherwise single-port write.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    // NOTE: this array is reset because a discarded job must not leak into reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: slot NB is the centre, slots 0..NB-1 the neighbours; out of range reads 0.
    always_comb begin
        int                    idx;
        logic signed [X_W-1:0] val;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        idx    = 0;
        val    = '0;
        rd_c_o = '0;
        rd_n_o = '{default: '0};
        for (int i = 0; i <= NB; i++) begin
            idx = int'(centre_i) + ((i == NB) ? 0 : nb_offset(i));
            val = '0;
            if (idx >= 0 && idx < N) begin
                if (we_i && idx == int'(waddr_i)) val = wdata_i;
                else                              val = mem_q[idx[IW-1:0]];
            end
            if (i == NB) rd_c_o    = val;
            else         rd_n_o[i] = val;
        end
    end
endmodule

// File: rtl/gsim_ctrl.sv
// Gauss-Seidel sequencer: loads b, sweeps the PE row by row over x with
// immediate write-back, then streams x out.
module gsim_ctrl
    import gsim_pkg::*;
#(
    parameter int N          = 16,
    parameter int N_ITER     = 8,
    parameter int PE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    gsim_ctrl_if.master bus
);
    localparam int IW = idx_w(N);
    localparam int SW = idx_w(N_ITER);
    localparam int TW = idx_w(PE_LATENCY + 1);

    state_e                state_q;
    logic [IW-1:0]         k_q, r_q, j_q, r_d, centre;
    logic [SW-1:0]         s_q;
    logic [TW-1:0]         t_q;
    logic signed [B_W-1:0] b_mem_q [N];
    logic                  b_ready_q, x_valid_q, busy_q;
    logic signed [X_W-1:0] x_data_q;
    logic signed [X_W-1:0] pe_in_q [NB];
    logic signed [B_W-1:0] pe_b_q;
    logic signed [X_W-1:0] wb_data, rd_c;
    logic signed [X_W-1:0] rd_n [NB];
    logic                  b_fire, x_fire, wb, last_row, last_sweep, last_wb, clr;

    assign b_fire     = (state_q == LOAD) && b_ready_q && bus.b_valid;
    assign x_fire     = x_valid_q && bus.x_ready;
    assign wb         = (state_q == CALC) && (t_q == TW'(PE_LATENCY));
    assign last_row   = (r_q == IW'(N - 1));
    assign last_sweep = (s_q == SW'(N_ITER - 1));
    assign last_wb    = wb && last_row && last_sweep;
    assign clr        = b_fire && (k_q == IW'(N - 1));
    assign wb_data    = sat38to32(bus.pe_out);

    // Next row, and which x index the read port serves this cycle.
    always_comb begin
        r_d    = last_row ? '0 : r_q + IW'(1);
        centre = r_d;
        if (state_q == DRAIN) centre = j_q + IW'(1);
        else if (last_wb)     centre = '0;
    end

    gsim_xbank #(.N(N)) u_xbank (
        .clk      (clk),
        .rst_n    (reset),
        .clr_i    (clr),
        .we_i     (wb),
        .waddr_i  (r_q),
        .wdata_i  (wb_data),
        .centre_i (centre),
        .rd_c_o   (rd_c),
        .rd_n_o   (rd_n)
    );

    // FSM, counters, b storage and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= LOAD;
            k_q       <= '0;
            r_q       <= '0;
            s_q       <= '0;
            j_q       <= '0;
            t_q       <= '0;
            b_ready_q <= 1'b0;
            x_valid_q <= 1'b0;
            x_data_q  <= '0;
            busy_q    <= 1'b0;
            pe_b_q    <= '0;
            for (int i = 0; i < NB; i++) pe_in_q[i] <= '0;
            for (int i = 0; i < N; i++)  b_mem_q[i] <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    b_ready_q <= 1'b1;
                    if (b_fire) begin
                        b_mem_q[k_q] <= bus.b_data;
                        if (k_q == IW'(N - 1)) begin
                            // x is cleared this edge, so every row-0 neighbour is 0.
                            state_q   <= CALC;
                            k_q       <= '0;
                            r_q       <= '0;
                            s_q       <= '0;
                            t_q       <= '0;
                            b_ready_q <= 1'b0;
                            busy_q    <= 1'b1;
                            pe_b_q    <= b_mem_q[0];
                            for (int i = 0; i < NB; i++) pe_in_q[i] <= '0;
                        end else begin
                            k_q <= k_q + IW'(1);
                        end
                    end
                end
                CALC: begin
                    if (wb) begin
                        t_q <= '0;
                        if (last_wb) begin
                            state_q   <= DRAIN;
                            busy_q    <= 1'b0;
                            x_valid_q <= 1'b1;
                            x_data_q  <= rd_c;
                            j_q       <= '0;
                            r_q       <= '0;
                            s_q       <= '0;
                            pe_b_q    <= '0;
                            for (int i = 0; i < NB; i++) pe_in_q[i] <= '0;
                        end else begin
                            r_q    <= r_d;
                            pe_b_q <= b_mem_q[r_d];
                            if (last_row) s_q <= s_q + SW'(1);
                            for (int i = 0; i < NB; i++) pe_in_q[i] <= rd_n[i];
                        end
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                DRAIN: begin
                    if (x_fire) begin
                        if (j_q == IW'(N - 1)) begin
                            state_q   <= LOAD;
                            x_valid_q <= 1'b0;
                            x_data_q  <= '0;
                            j_q       <= '0;
                            k_q       <= '0;
                            b_ready_q <= 1'b1;
                        end else begin
                            j_q      <= j_q + IW'(1);
                            x_data_q <= rd_c;
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.b_ready = b_ready_q;
    assign bus.x_valid = x_valid_q;
    assign bus.x_data  = x_data_q;
    assign bus.busy    = busy_q;
    assign bus.pe_b    = pe_b_q;
    assign bus.pe_in_1 = pe_in_q[0];
    assign bus.pe_in_2 = pe_in_q[1];
    assign bus.pe_in_3 = pe_in_q[2];
    assign bus.pe_in_4 = pe_in_q[3];
    assign bus.pe_in_5 = pe_in_q[4];
    assign bus.pe_in_6 = pe_in_q[5];
endmodule

// File: tb/tb_gsim_ctrl.sv
// Directed bench for gsim_ctrl: three instances with different sweep counts
// and PE latencies, each driven by a PE stub built from a delay line.
module tb_gsim_ctrl;
    localparam int NN   = 16;
    localparam int NDUT = 3;
    localparam int NIT [NDUT] = '{1, 2, 1};
    localparam int LAT [NDUT] = '{1, 1, 3};
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic                b_valid = 1'b0;
    logic signed [15:0]  b_data  = '0;
    logic                x_ready = 1'b0;
    int                  sel       = 0;
    int                  stub_mode = 0;
    int                  n_checks  = 0;
    int                  n_fail    = 0;
    int                  mb [NN];
    longint              mx [NN];
    longint              exp_x [NN];

    logic                obs_b_ready [NDUT];
    logic                obs_x_valid [NDUT];
    logic                obs_busy    [NDUT];
    logic signed [31:0]  obs_x_data  [NDUT];
    logic signed [15:0]  obs_pe_b    [NDUT];
    logic signed [31:0]  obs_in      [NDUT][6];

    always #5 clk = ~clk;

    // PE stub: 0 -> b+x[r-1], 1 -> b+x[r+1], 2 -> 2^31, 3 -> -2^31-1, else 0.
    function automatic logic signed [37:0] stub_f(input int mode, input logic signed [15:0] b,
                                                  input logic signed [31:0] up,
                                                  input logic signed [31:0] dn);
        logic signed [37:0] bb, uu, dd, v;
        bb = b;
        uu = up;
        dd = dn;
        case (mode)
            0:       v = bb + dd;
            1:       v = bb + uu;
            2:       v = 38'sd2147483648;
            3:       v = -38'sd2147483649;
            default: v = '0;
        endcase
        return v;
    endfunction

    gsim_ctrl_if bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic signed [37:0] dl [LAT[g]];

        assign bus[g].b_valid = b_valid && (sel == g);
        assign bus[g].b_data  = b_data;
        assign bus[g].x_ready = x_ready && (sel == g);
        assign bus[g].pe_out  = dl[LAT[g] - 1];

        always @(posedge clk) begin
            dl[0] <= stub_f(stub_mode, bus[g].pe_b, bus[g].pe_in_5, bus[g].pe_in_6);
            for (int i = 1; i < LAT[g]; i++) dl[i] <= dl[i - 1];
        end

        gsim_ctrl #(.N(NN), .N_ITER(NIT[g]), .PE_LATENCY(LAT[g])) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );

        assign obs_b_ready[g] = bus[g].b_ready;
        assign obs_x_valid[g] = bus[g].x_valid;
        assign obs_busy[g]    = bus[g].busy;
        assign obs_x_data[g]  = bus[g].x_data;
        assign obs_pe_b[g]    = bus[g].pe_b;
        assign obs_in[g][0]   = bus[g].pe_in_1;
        assign obs_in[g][1]   = bus[g].pe_in_2;
        assign obs_in[g][2]   = bus[g].pe_in_3;
        assign obs_in[g][3]   = bus[g].pe_in_4;
        assign obs_in[g][4]   = bus[g].pe_in_5;
        assign obs_in[g][5]   = bus[g].pe_in_6;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat_model(input longint v);
        longint r;
        r = v;
        if (v > MAXV) r = MAXV;
        if (v < MINV) r = MINV;
        return r;
    endfunction

    // Expected operand slot i (pe_in_{i+1}) for a row, from the bench's own x copy.
    function automatic longint exp_nb(input int row, input int i);
        int offs [6] = '{3, -3, 2, -2, 1, -1};
        int idx;
        idx = row + offs[i];
        return (idx >= 0 && idx < NN) ? mx[idx] : 64'sd0;
    endfunction

    function automatic longint stub_model(input int mode, input int row);
        longint v;
        case (mode)
            0:       v = mb[row] + ((row > 0) ? mx[row - 1] : 64'sd0);
            1:       v = mb[row] + ((row < NN - 1) ? mx[row + 1] : 64'sd0);
            2:       v = 64'sd2147483648;
            3:       v = -64'sd2147483649;
            default: v = 0;
        endcase
        return sat_model(v);
    endfunction

    task automatic set_exp(input int kind);
        for (int i = 0; i < NN; i++) begin
            case (kind)
                0:       exp_x[i] = i + 1;
                1:       exp_x[i] = (i < NN - 1) ? 2 : 1;
                2:       exp_x[i] = MAXV;
                3:       exp_x[i] = MINV;
                default: exp_x[i] = 0;
            endcase
        end
    endtask

    // Offer b[0..15]; entered and left on a falling edge.
    task automatic load_b(input int bmode);
        int k = 0;
        int guard = 0;
        for (int i = 0; i < NN; i++) mb[i] = (bmode == 1) ? i : 1;
        while (k < NN && guard < 100) begin
            b_valid = 1'b1;
            b_data  = 16'(mb[k]);
            if (obs_b_ready[sel]) k++;
            guard++;
            @(negedge clk);
        end
        b_valid = 1'b0;
        check("load handshakes", k, NN);
    endtask

    // Walk the CALC phase cycle by cycle; abort_at >= 0 stops at that cycle.
    task automatic run_calc(input int abort_at);
        int period = LAT[sel] + 1;
        int total  = NN * NIT[sel] * period;
        int row;
        for (int i = 0; i < NN; i++) mx[i] = 0;
        for (int c = 0; c < total; c++) begin
            row = (c / period) % NN;
            check($sformatf("busy c%0d", c), obs_busy[sel], 1);
            check($sformatf("b_ready in CALC c%0d", c), obs_b_ready[sel], 0);
            check($sformatf("x_valid in CALC c%0d", c), obs_x_valid[sel], 0);
            check($sformatf("pe_b c%0d r%0d", c, row), obs_pe_b[sel], mb[row]);
            for (int i = 0; i < 6; i++)
                check($sformatf("pe_in_%0d c%0d r%0d", i + 1, c, row), obs_in[sel][i], exp_nb(row, i));
            if (c == abort_at) begin
                b_valid = 1'b0;
                return;
            end
            if (c % period == LAT[sel]) mx[row] = stub_model(stub_mode, row);
            b_valid = (c % 5 == 2);
            b_data  = 16'sd99;
            @(negedge clk);
        end
        b_valid = 1'b0;
        check("busy after CALC", obs_busy[sel], 0);
    endtask

    // Consume x[0..15]; bp_at >= 0 holds x_ready low for 3 cycles at that index.
    task automatic drain(input int bp_at);
        int j = 0;
        int stall = 0;
        while (j < NN && stall <= 3) begin
            check($sformatf("x_valid j%0d", j), obs_x_valid[sel], 1);
            check($sformatf("x_data j%0d", j), obs_x_data[sel], exp_x[j]);
            check($sformatf("busy in DRAIN j%0d", j), obs_busy[sel], 0);
            check($sformatf("b_ready in DRAIN j%0d", j), obs_b_ready[sel], 0);
            if (j == bp_at && stall < 3) begin
                x_ready = 1'b0;
                stall++;
            end else begin
                x_ready = 1'b1;
                j++;
            end
            @(negedge clk);
        end
        x_ready = 1'b0;
        check("x_valid after DRAIN", obs_x_valid[sel], 0);
        check("x_data after DRAIN", obs_x_data[sel], 0);
        check("b_ready after DRAIN", obs_b_ready[sel], 1);
    endtask

    task automatic do_job(input int s, input int mode, input int bmode, input int kind,
                          input int bp_at);
        sel       = s;
        stub_mode = mode;
        set_exp(kind);
        load_b(bmode);
        run_calc(-1);
        drain(bp_at);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s b_ready d%0d", tag, g), obs_b_ready[g], 0);
            check($sformatf("%s x_valid d%0d", tag, g), obs_x_valid[g], 0);
            check($sformatf("%s x_data d%0d", tag, g), obs_x_data[g], 0);
            check($sformatf("%s busy d%0d", tag, g), obs_busy[g], 0);
            check($sformatf("%s pe_b d%0d", tag, g), obs_pe_b[g], 0);
            for (int i = 0; i < 6; i++)
                check($sformatf("%s pe_in_%0d d%0d", tag, i + 1, g), obs_in[g][i], 0);
        end
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++)
            check($sformatf("b_ready before first edge d%0d", g), obs_b_ready[g], 0);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++)
            check($sformatf("b_ready after release d%0d", g), obs_b_ready[g], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // b+x[r-1], one sweep, latency 1: 1..16, backpressure at j=3.
        do_job(0, 0, 0, 0, 3);
        // Zero stub with b[i]=i: operand and pe_b sequencing, all results 0.
        do_job(0, 4, 1, 4, -1);
        // b+x[r+1], two sweeps: x[0..14]=2, x[15]=1.
        do_job(1, 1, 0, 1, -1);
        // Saturation both ways.
        do_job(1, 2, 0, 2, -1);
        do_job(1, 3, 0, 3, 5);
        // Latency 3: rows held 4 cycles, CALC lasts 64 cycles, result 1..16.
        do_job(2, 0, 0, 0, -1);
        do_job(2, 4, 1, 4, 0);

        // Reset at row 7 of sweep 1 on the two-sweep instance, then a fresh job.
        sel       = 1;
        stub_mode = 0;
        load_b(0);
        run_calc((NN + 7) * (LAT[1] + 1));
        reset = 1'b0;
        #1;
        check_reset_outputs("mid-CALC reset");
        @(negedge clk);
        check_reset_outputs("mid-CALC reset held");
        release_reset();
        do_job(1, 0, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
